// File: rtl/decode_queue.sv
// Instruction word queue feeding the execution sequencer one decoded half-instruction at a time.
// Handles native and BESM-6 half formats, mid-word entry, and flush on control transfer.
module decode_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter bit          BESM6_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_word,
    input  logic                       in_pe,
    input  logic                       in_rh,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_tkk,
    output logic [3:0]                 out_ir,
    output logic [7:0]                 out_op,
    output logic                       out_extop,
    output logic                       out_ir15,
    output logic [19:0]                out_addr,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [63:0]      mem_word [DEPTH];
    logic [DEPTH-1:0] mem_pe;
    logic [DEPTH-1:0] mem_rh;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          hsel_q, hsel_d;

    logic push, fire, pop;

    logic [64:1] dc;
    logic        head_pe;
    logic        head_rh;
    logic [7:0]  bop;
    logic [7:0]  xop;

    // No bypass: fullness is judged on the registered level only.
    assign in_ready  = (level_q != LW'(DEPTH)) & ~flush;
    assign out_valid = (level_q != '0);
    assign level     = level_q;

    assign push = in_valid & in_ready;
    assign fire = out_valid & out_ready;
    assign pop  = fire & out_tkk;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hsel_d   = hsel_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            hsel_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
            // Left half fired: stay on this word for its right half.
            if (fire) hsel_d = ~out_tkk;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hsel_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hsel_q   <= hsel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr_q] <= in_word;
            mem_pe[wr_ptr_q]   <= in_pe & BESM6_EN;
            mem_rh[wr_ptr_q]   <= in_rh;
        end
    end

    assign dc      = mem_word[rd_ptr_q];
    assign head_pe = mem_pe[rd_ptr_q];
    assign head_rh = mem_rh[rd_ptr_q];
    assign out_tkk = head_rh | hsel_q;

    always_comb begin
        out_ir    = '0;
        out_addr  = '0;
        out_op    = '0;
        out_extop = 1'b0;
        bop       = '0;
        xop       = '0;
        if (head_pe) begin
            if (!out_tkk) begin
                out_ir = {dc[64], dc[59:57]};
                if (dc[56]) begin
                    bop      = {dc[56:52], 3'b000};
                    out_addr = {5'b0, dc[51:37]};
                end else begin
                    bop      = {2'b00, dc[54:49]};
                    out_addr = {5'b0, {3{dc[55]}}, dc[48:37]};
                end
            end else begin
                out_ir = dc[36:33];
                if (dc[32]) begin
                    bop      = {dc[32:28], 3'b000};
                    out_addr = {5'b0, dc[27:13]};
                end else begin
                    bop      = {2'b00, dc[30:25]};
                    out_addr = {5'b0, {3{dc[31]}}, dc[24:13]};
                end
            end
            out_op = bop;
        end else begin
            if (!out_tkk) begin
                out_ir   = dc[64:61];
                bop      = dc[60:53];
                xop      = dc[52:45];
                out_addr = dc[52:33];
            end else begin
                out_ir   = dc[32:29];
                bop      = dc[28:21];
                xop      = dc[20:13];
                out_addr = dc[20:1];
            end
            out_extop = (bop == 8'h3F);
            out_op    = out_extop ? xop : bop;
        end
    end

    assign out_ir15 = (out_ir == 4'd15);

endmodule

// File: tb/tb_decode_queue.sv
// Randomised and directed checks of decode_queue against a queue-based reference model.
// A second instance with BESM-6 decode disabled runs on the same stimulus.
module tb_decode_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush, in_valid, in_pe, in_rh, out_ready;
    logic [63:0]   in_word;
    logic          in_ready, out_valid, out_tkk, out_extop, out_ir15;
    logic [3:0]    out_ir;
    logic [7:0]    out_op;
    logic [19:0]   out_addr;
    logic [LW-1:0] level;
    logic          in_ready0, out_valid0, out_tkk0, out_extop0, out_ir150;
    logic [3:0]    out_ir0;
    logic [7:0]    out_op0;
    logic [19:0]   out_addr0;
    logic [LW-1:0] level0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] w;
        bit          pe;
        bit          rh;
    } ent_t;

    ent_t mq[$];
    bit   m_hsel = 1'b0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .BESM6_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_word(in_word), .in_pe(in_pe), .in_rh(in_rh),
        .out_valid(out_valid), .out_ready(out_ready), .out_tkk(out_tkk), .out_ir(out_ir),
        .out_op(out_op), .out_extop(out_extop), .out_ir15(out_ir15), .out_addr(out_addr),
        .level(level)
    );

    decode_queue #(.DEPTH(DEPTH), .BESM6_EN(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready0), .in_word(in_word), .in_pe(in_pe), .in_rh(in_rh),
        .out_valid(out_valid0), .out_ready(out_ready), .out_tkk(out_tkk0), .out_ir(out_ir0),
        .out_op(out_op0), .out_extop(out_extop0), .out_ir15(out_ir150), .out_addr(out_addr0),
        .level(level0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Field of the word in 1-based bit numbering, bits hi..lo.
    function automatic logic [63:0] fld(input logic [63:0] w, input int hi, input int lo);
        return (w >> (lo - 1)) & ((64'd1 << (hi - lo + 1)) - 64'd1);
    endfunction

    task automatic ref_decode(input logic [63:0] w, input bit pe, input bit tkk,
                              output logic [3:0] ir, output logic [7:0] op,
                              output logic ext, output logic [19:0] addr);
        int s;
        int b;
        logic [63:0] bop;
        if (!pe) begin
            s    = tkk ? 32 : 0;
            ir   = 4'(fld(w, 64 - s, 61 - s));
            bop  = fld(w, 60 - s, 53 - s);
            addr = 20'(fld(w, 52 - s, 33 - s));
            ext  = (bop == 64'h3F);
            op   = ext ? 8'(fld(w, 52 - s, 45 - s)) : 8'(bop);
        end else begin
            b    = tkk ? 32 : 56;
            ir   = tkk ? 4'(fld(w, 36, 33)) : 4'(fld(w, 64, 64) * 8 + fld(w, 59, 57));
            ext  = 1'b0;
            if (fld(w, b, b) == 1) begin
                op   = 8'(fld(w, b, b - 4) * 8);
                addr = 20'(fld(w, b - 5, b - 19));
            end else begin
                op   = 8'(fld(w, b - 2, b - 7));
                addr = 20'(fld(w, b - 1, b - 1) * 64'h7000 + fld(w, b - 8, b - 19));
            end
        end
    endtask

    task automatic check_all();
        logic [3:0]  ir;
        logic [7:0]  op;
        logic        ext;
        logic [19:0] addr;
        bit          tkk;
        bit          exp_ready;
        exp_ready = (mq.size() != DEPTH) && !flush;
        check("in_ready", in_ready, exp_ready);
        check("in_ready0", in_ready0, exp_ready);
        check("level", level, mq.size());
        check("level0", level0, mq.size());
        check("out_valid", out_valid, mq.size() != 0);
        check("out_valid0", out_valid0, mq.size() != 0);
        if (mq.size() != 0) begin
            tkk = mq[0].rh | m_hsel;
            ref_decode(mq[0].w, mq[0].pe, tkk, ir, op, ext, addr);
            check("tkk", out_tkk, tkk);
            check("ir", out_ir, ir);
            check("op", out_op, op);
            check("extop", out_extop, ext);
            check("ir15", out_ir15, ir == 4'd15);
            check("addr", out_addr, addr);
            ref_decode(mq[0].w, 1'b0, tkk, ir, op, ext, addr);
            check("tkk0", out_tkk0, tkk);
            check("ir0", out_ir0, ir);
            check("op0", out_op0, op);
            check("extop0", out_extop0, ext);
            check("ir15_0", out_ir150, ir == 4'd15);
            check("addr0", out_addr0, addr);
        end
    endtask

    task automatic model_step();
        bit push;
        push = in_valid && (mq.size() != DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            m_hsel = 1'b0;
        end else begin
            if (mq.size() != 0 && out_ready) begin
                if (mq[0].rh || m_hsel) begin
                    void'(mq.pop_front());
                    m_hsel = 1'b0;
                end else begin
                    m_hsel = 1'b1;
                end
            end
            if (push) mq.push_back('{in_word, in_pe, in_rh});
        end
    endtask

    task automatic cycle(input bit v, input logic [63:0] w, input bit pe, input bit rh,
                         input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = v;
        in_word   = w;
        in_pe     = pe;
        in_rh     = rh;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_all();
        model_step();
    endtask

    logic [63:0] w1, w2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_pe     = 1'b0;
        in_rh     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Native word, both halves
        w1 = 64'h53F12000_F1000345;
        cycle(1, w1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("nat_l_tkk", out_tkk, 0);
        check("nat_l_ir", out_ir, 5);
        check("nat_l_extop", out_extop, 1);
        check("nat_l_op", out_op, 8'h12);
        check("nat_l_addr", out_addr, 20'h12000);
        check("nat_l_ir15", out_ir15, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("nat_r_tkk", out_tkk, 1);
        check("nat_r_ir", out_ir, 15);
        check("nat_r_ir15", out_ir15, 1);
        check("nat_r_extop", out_extop, 0);
        check("nat_r_op", out_op, 8'h10);
        check("nat_r_addr", out_addr, 20'h00345);
        cycle(0, 0, 0, 0, 0, 0);
        check("nat_done_level", level, 0);

        // BESM-6 right-half entry
        w2 = '0;
        w2[35:32] = 4'd3;
        w2[31]    = 1'b0;
        w2[30]    = 1'b1;
        w2[29:24] = 6'h21;
        w2[23:12] = 12'h7FF;
        cycle(1, w2, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("besm_tkk", out_tkk, 1);
        check("besm_ir", out_ir, 3);
        check("besm_op", out_op, 8'h21);
        check("besm_extop", out_extop, 0);
        check("besm_addr", out_addr, 20'h077FF);
        cycle(0, 0, 0, 0, 1, 0);
        check("besm_single", out_valid, 0);
        // Same word from the left half, both decoders
        cycle(1, w2, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // Fill to full, extra offers refused, then drain across the pointer wrap
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(1, {$urandom, $urandom}, 1'($urandom), 0, 0, 0);
        end
        check("full_level", level, DEPTH);
        check("full_in_ready", in_ready, 0);
        for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("drained", out_valid, 0);

        // Hold, then flush with a concurrent offer
        cycle(1, {$urandom, $urandom}, 0, 0, 0, 0);
        cycle(1, {$urandom, $urandom}, 1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        cycle(1, {$urandom, $urandom}, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        check("flush_level", level, 0);
        check("flush_valid", out_valid, 0);

        // Reset after the left half has fired
        cycle(1, w1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("pre_rst_tkk", out_tkk, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", level, 0);
        mq.delete();
        m_hsel = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, w1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("post_rst_tkk", out_tkk, 0);
        check("post_rst_ir", out_ir, 5);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 47) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, sequential successor to the combinational half-word instruction decoder.
- Accepts 64-bit instruction words into a parametrised FIFO.
- Presents them to the execution sequencer as a stream of decoded half-instructions: left half, then right half.
- Supports mid-word entry (jump to right half), per-word BESM-6 compatibility mode, and flush on control transfer.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
BESM6_EN, 1, 1 enables BESM-6 decode; 0 forces native decode (pe input ignored)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all queued words and half state
in_valid  input  1  word offered
in_ready  output  1  queue can accept word
in_word  input  64  instruction word, bits [64:1]
in_pe  input  1  word uses BESM-6 format
in_rh  input  1  start execution at right half of this word
out_valid  output  1  decoded half-instruction available
out_ready  input  1  consumer accepts half-instruction
out_tkk  output  1  0 = left half, 1 = right half
out_ir  output  4  modifier index
out_op  output  8  opcode
out_extop  output  1  extended-opcode flag
out_ir15  output  1  stack mode (out_ir == 15)
out_addr  output  20  address field
level  output  $clog2(DEPTH+1)  stored word count

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low. Reset clears pointers, level, and half-select register hsel.
- Outputs after reset: in_ready=1, out_valid=0, level=0. Decoded outputs reflect the empty head entry; the bench must not check them while out_valid=0.
- Entry contents: {word, pe & BESM6_EN, rh}.
- Push: in_valid & in_ready. in_ready = (level != DEPTH) & !flush. No bypass: a full queue refuses a push even if a pop occurs in the same cycle.
- Latency: a word pushed into an empty queue gives out_valid=1 on the next cycle. out_valid = (level != 0).
- Effective half select: out_tkk = head.rh | hsel.
- Fire (out_valid & out_ready):
  - out_tkk=0: hsel<=1; the word stays at the head.
  - out_tkk=1: pop the head and set hsel<=0.
  - A word with rh=1 therefore yields exactly one half-instruction.
- Simultaneous push and pop on a non-full queue: level unchanged; pointers wrap modulo DEPTH.
- Flush: dominates push and pop in the same cycle. Level goes to 0, pointers to 0, hsel to 0, and the offered word is discarded.
- Decode is combinational from the head entry and out_tkk; the outputs are stable while out_valid & !out_ready.
- Native decode (pe=0):
  - Left half: ir=dc[64:61], bop=dc[60:53], xop=dc[52:45], addr=dc[52:33].
  - Right half: ir=dc[32:29], bop=dc[28:21], xop=dc[20:13], addr=dc[20:1].
  - extop = (bop == 8'h3F); op = extop ? xop : bop.
- BESM-6 decode (pe=1), extop=0, op=bop:
  - Left half: ir={dc[64],dc[59:57]}.
    - If dc[56]=1: bop={dc[56:52],3'b0}, addr={5'b0,dc[51:37]}.
    - If dc[56]=0: bop={2'b0,dc[54:49]}, addr={5'b0,{3{dc[55]}},dc[48:37]}.
  - Right half: ir=dc[36:33].
    - If dc[32]=1: bop={dc[32:28],3'b0}, addr={5'b0,dc[27:13]}.
    - If dc[32]=0: bop={2'b0,dc[30:25]}, addr={5'b0,{3{dc[31]}},dc[24:13]}.
- ir15 = (ir == 4'd15) in both modes.
- Reset mid-stream: all state is lost immediately. out_valid drops asynchronously with reset_n low.

Test Plan:
- Native word 64'h53F12000_F1000345, pe=0, rh=0, out_ready=1 → two fires.
  - First fire: tkk=0, ir=5, extop=1, op=8'h12, addr=20'h12000, ir15=0.
  - Second fire: tkk=1, ir=15, ir15=1, extop=0, op=8'h10, addr=20'h00345. Then level=0.
- BESM-6 right half (pe=1, rh=1) with dc[36:33]=3, dc[32]=0, dc[31]=1, dc[30:25]=6'h21, dc[24:13]=12'h7FF → single fire: tkk=1, ir=3, op=8'h21, extop=0, addr=20'h077FF. No left-half output.
- Same word with BESM6_EN=0 → native decode of both halves; pe is ignored.
- Fill with out_ready=0 → level reaches DEPTH and in_ready=0. Further in_valid is ignored. Drain 2·DEPTH halves in push order across pointer wrap.
- Two words queued, hold out_ready=0 for 3 cycles → outputs stable. Assert flush together with in_valid → next cycle level=0, out_valid=0, pushed word absent.
- Assert reset_n=0 mid-word (after the left half fired) → out_valid=0 at once. After release, a new word starts at its left half.
